idma_desc64_apb_submitter: RTL and testbench
============================================

// Module: idma_desc64_apb_submitter
// PURPOSE
//  APB initiator that submits 64-bit descriptor addresses to the desc64 frontend register file.
//  Buffers addresses from a ready/valid stream in a small FIFO.
//  Issues one APB write per address to the DESC_ADDR register.
//  Tolerates the responder stalling PREADY while its descriptor FIFO is full.
//  Sits in a host-side or test-harness cluster; its apb_req_o drives the desc64 register wrapper.
// PARAMETERS
//  AddrWidth      32       APB PADDR width
//  DataWidth      64       APB PWDATA/PRDATA width; must be >= 64
//  DescAddrOffset 'h0      PADDR used for every write (DESC_ADDR register offset)
//  FifoDepth      4        address buffer entries; >= 2, power of two
//  StallCycles    1024     PREADY-low cycles in ACCESS before stall_o rises; 0 disables
//  apb_req_t      logic    APB request struct: psel, penable, pwrite, pprot, paddr, pwdata, pstrb
//  apb_rsp_t      logic    APB response struct: pready, prdata, pslverr
// PORTS
//  clk_i          in   1          clock, all logic rising-edge
//  rst_i          in   1          asynchronous reset, active-high
//  desc_addr_i    in   64         descriptor address to submit
//  desc_valid_i   in   1          desc_addr_i valid
//  desc_ready_o   out  1          FIFO can accept; = !fifo_full (pop in same cycle not considered)
//  apb_req_o      out  apb_req_t  APB initiator request
//  apb_rsp_i      in   apb_rsp_t  APB responder response
//  busy_o         out  1          FIFO non-empty or FSM != IDLE
//  err_o          out  1          1-cycle pulse: completed write had PSLVERR=1
//  err_cnt_o      out  16         saturating count of PSLVERR completions
//  stall_o        out  1          current access has waited >= StallCycles with PREADY=0
//  clear_err_i    in   1          synchronous clear of err_cnt_o
// BEHAVIOUR
//  Reset (rst_i=1, takes effect immediately):
//   - FIFO flushed; FSM=IDLE.
//   - apb_req_o all fields 0; err_o=0, err_cnt_o=0, stall_o=0, busy_o=0.
//   - desc_ready_o=1.
//   - Reset mid-access drops PSEL at once; the in-flight entry is lost.
//  FIFO:
//   - Push on desc_valid_i&&desc_ready_o; pop on APB completion only.
//   - Push and pop in the same cycle are allowed when not full.
//   - Pointers wrap modulo FifoDepth; full/empty use an extra wrap bit.
//  FSM, all APB outputs registered:
//   - IDLE: fifo non-empty -> SETUP.
//   - SETUP: psel=1, penable=0, pwrite=1, paddr=DescAddrOffset, pwdata=zero-extended FIFO head,
//     pstrb=all ones, pprot=0. Always -> ACCESS.
//   - ACCESS: psel=1, penable=1, all other fields held stable.
//     On pready=1 the entry is popped; then -> SETUP if another entry is present, else -> IDLE.
//     On pready=0 the FSM stays in ACCESS.
//  Latency:
//   - Address accepted at edge N into an empty FIFO in IDLE -> SETUP from edge N+1, ACCESS from N+2.
//   - Completion at the first edge >= N+3 with pready=1.
//   - Back-to-back throughput: one write per 2 cycles with zero-wait responder.
//  Errors:
//   - pready&pslverr in ACCESS: entry is still popped (no retry); err_o pulses the next cycle.
//   - err_cnt_o increments by 1 and saturates at 16'hFFFF.
//   - clear_err_i wins over a simultaneous increment (result 0).
//  Stall monitor:
//   - 16-bit wait counter runs in ACCESS while pready=0 and is zeroed on completion or on leaving ACCESS.
//   - stall_o=1 once counter >= StallCycles-1 at an edge; it stays high until completion.
//   - The transfer is never aborted, which keeps it APB-legal.
//  prdata is ignored.
// TESTING
//  1 Reset, push 0x0000_0001_0000_1000, pready tied 1 -> SETUP at N+1, ACCESS at N+2,
//    pwdata=0x1_0000_1000, paddr=DescAddrOffset, busy_o=0 from N+4.
//  2 Push 4 addresses back-to-back (FifoDepth=4), pready=1 -> desc_ready_o stays 1 or drops for one
//    cycle at most; 4 writes in order, 2 cycles each.
//  3 Hold pready=0; push 5 addresses -> desc_ready_o=0 after 4 (incl. in-flight head); PSEL/PADDR/PWDATA
//    stable; release -> all complete in order.
//  4 StallCycles=8, pready=0 for 20 cycles -> stall_o rises after 8th ACCESS cycle, falls after completion.
//  5 pslverr=1 on 2nd of 3 writes -> err_o one pulse, err_cnt_o=1, 3rd write still issued;
//    clear_err_i -> 0.
//  6 Assert rst_i during ACCESS -> psel/penable 0 same cycle, FIFO empty, desc_ready_o=1.

Source files
------------

// File: rtl/idma_desc64_apb_submitter.sv
// rtl/idma_desc64_apb_submitter.sv - APB initiator submitting 64-bit descriptor addresses
//
// Purpose: buffers descriptor addresses from a ready/valid stream in a small FIFO and
// issues one APB write per address to the desc64 frontend DESC_ADDR register.
// Waits out responder PREADY stalls without aborting, and flags long stalls.
//
// Ports:
//   clk_i, rst_i      clock (rising edge), asynchronous active-high reset
//   desc_addr_i       descriptor address to submit
//   desc_valid_i      desc_addr_i valid
//   desc_ready_o      buffer can accept (not full)
//   apb_req_o         registered APB request (psel/penable/pwrite/pprot/paddr/pwdata/pstrb)
//   apb_rsp_i         APB response (pready/prdata/pslverr); prdata is ignored
//   busy_o            buffer non-empty or a transfer in progress
//   err_o             one-cycle pulse after a write completed with PSLVERR
//   err_cnt_o         saturating count of PSLVERR completions
//   stall_o           current access has waited at least StallCycles with PREADY low
//   clear_err_i       synchronous clear of err_cnt_o

package idma_desc64_apb_submitter_pkg;

  typedef struct packed {
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [2:0]  pprot;
    logic [31:0] paddr;
    logic [63:0] pwdata;
    logic [7:0]  pstrb;
  } apb_req_t;

  typedef struct packed {
    logic        pready;
    logic [63:0] prdata;
    logic        pslverr;
  } apb_rsp_t;

endpackage

module idma_desc64_apb_submitter #(
  parameter int unsigned          AddrWidth      = 32,
  parameter int unsigned          DataWidth      = 64,
  parameter logic [AddrWidth-1:0] DescAddrOffset = '0,
  parameter int unsigned          FifoDepth      = 4,
  parameter int unsigned          StallCycles    = 1024,
  parameter type apb_req_t = idma_desc64_apb_submitter_pkg::apb_req_t,
  parameter type apb_rsp_t = idma_desc64_apb_submitter_pkg::apb_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] desc_addr_i,
  input  logic        desc_valid_i,
  output logic        desc_ready_o,
  output apb_req_t    apb_req_o,
  input  apb_rsp_t    apb_rsp_i,
  output logic        busy_o,
  output logic        err_o,
  output logic [15:0] err_cnt_o,
  output logic        stall_o,
  input  logic        clear_err_i
);

  localparam int unsigned IdxW = $clog2(FifoDepth);
  localparam int unsigned PtrW = IdxW + 1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Address FIFO. The head stays in the FIFO while its write is in flight and is
  // only popped on completion, so an in-flight entry occupies a slot.
  // ---------------------------------------------------------------------------
  logic [63:0]     mem_q [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] fifo_count;
  logic [IdxW-1:0] wr_idx, rd_idx, rd_idx_next;
  logic            fifo_empty, fifo_full;
  logic            push, pop;
  logic [63:0]     fifo_head, fifo_head_next;

  assign wr_idx      = wr_ptr_q[IdxW-1:0];
  assign rd_idx      = rd_ptr_q[IdxW-1:0];
  assign rd_idx_next = rd_idx + IdxW'(1);
  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  // Full when the index bits match but the wrap bits differ.
  assign fifo_full   = (wr_idx == rd_idx) && (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]);
  assign fifo_count  = wr_ptr_q - rd_ptr_q;
  assign fifo_head      = mem_q[rd_idx];
  assign fifo_head_next = mem_q[rd_idx_next];

  assign desc_ready_o = !fifo_full;
  assign push         = desc_valid_i && !fifo_full;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_idx] <= desc_addr_i;
  end

  // ---------------------------------------------------------------------------
  // APB FSM
  // ---------------------------------------------------------------------------
  state_e   state_q, state_d;
  apb_req_t req_q, req_d;
  logic     more_pending;

  assign pop = (state_q == StAccess) && apb_rsp_i.pready;
  // Another entry behind the head that completes this cycle.
  assign more_pending = (fifo_count > PtrW'(1));

  function automatic apb_req_t setup_req(input logic [63:0] addr);
    apb_req_t r;
    r        = '0;
    r.psel   = 1'b1;
    r.pwrite = 1'b1;
    r.paddr  = DescAddrOffset;
    r.pwdata = DataWidth'(addr);
    r.pstrb  = '1;
    return r;
  endfunction

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (!fifo_empty) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (apb_rsp_i.pready) state_d = more_pending ? StSetup : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output logic: the request for the next cycle is computed here and registered,
  // so the bus sees clean flop outputs and ACCESS simply holds SETUP's fields.
  always_comb begin
    req_d = req_q;
    case (state_q)
      StIdle:   req_d = fifo_empty ? '0 : setup_req(fifo_head);
      StSetup:  req_d.penable = 1'b1;
      StAccess: if (apb_rsp_i.pready) req_d = more_pending ? setup_req(fifo_head_next) : '0;
      default:  req_d = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Error reporting and stall monitor
  // ---------------------------------------------------------------------------
  logic        err_q, err_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        stall_q, stall_d;
  logic        waiting, stall_hit;

  assign waiting = (state_q == StAccess) && !apb_rsp_i.pready;
  assign stall_hit = (StallCycles != 0) && (32'(wait_cnt_q) >= (StallCycles - 32'd1));

  always_comb begin
    err_d     = pop && apb_rsp_i.pslverr;
    err_cnt_d = err_cnt_q;
    if (clear_err_i) begin
      err_cnt_d = '0;
    end else if (err_d && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end

    wait_cnt_d = '0;
    stall_d    = 1'b0;
    if (waiting) begin
      wait_cnt_d = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
      // Sticky until the access completes; the transfer itself is never aborted.
      stall_d    = stall_q || stall_hit;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      req_q      <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      wait_cnt_q <= '0;
      stall_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      req_q      <= req_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      stall_q    <= stall_d;
    end
  end

  logic unused_prdata;
  assign unused_prdata = ^apb_rsp_i.prdata;

  assign apb_req_o = req_q;
  assign busy_o    = !fifo_empty || (state_q != StIdle);
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;
  assign stall_o   = stall_q;

endmodule

// File: tb/tb_idma_desc64_apb_submitter.sv
// tb/tb_idma_desc64_apb_submitter.sv - self-checking bench for idma_desc64_apb_submitter
module tb_idma_desc64_apb_submitter;
  import idma_desc64_apb_submitter_pkg::*;

  localparam logic [31:0] Offs = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] desc_addr;
  logic        desc_valid;
  logic        desc_ready;
  apb_req_t    apb_req;
  apb_rsp_t    apb_rsp;
  logic        busy, err, stall, clear_err;
  logic [15:0] err_cnt;

  logic        pready_tb;
  logic        err_en;
  logic [63:0] err_addr;

  always #5 clk = ~clk;

  always_comb begin
    apb_rsp         = '0;
    apb_rsp.pready  = pready_tb;
    apb_rsp.pslverr = err_en && apb_req.psel && apb_req.penable && (apb_req.pwdata == err_addr);
  end

  idma_desc64_apb_submitter #(
    .AddrWidth     (32),
    .DataWidth     (64),
    .DescAddrOffset(Offs),
    .FifoDepth     (4),
    .StallCycles   (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .desc_addr_i (desc_addr),
    .desc_valid_i(desc_valid),
    .desc_ready_o(desc_ready),
    .apb_req_o   (apb_req),
    .apb_rsp_i   (apb_rsp),
    .busy_o      (busy),
    .err_o       (err),
    .err_cnt_o   (err_cnt),
    .stall_o     (stall),
    .clear_err_i (clear_err)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          comp_cnt = 0;
  int          err_pulses = 0;
  logic [63:0] exp_q[$];
  int          comp_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Completion monitor: samples on the falling edge; a completion happens at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (err) err_pulses++;
      if (apb_req.psel && apb_req.penable && apb_rsp.pready) begin
        logic [63:0] e;
        comp_cnt++;
        comp_cyc.push_back(cyc);
        check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_pwdata", apb_req.pwdata, e);
          check("sb_paddr", 64'(apb_req.paddr), 64'(Offs));
          check("sb_pwrite", 64'(apb_req.pwrite), 64'd1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] a, output int waited);
    waited     = 0;
    desc_addr  = a;
    desc_valid = 1'b1;
    while (!desc_ready && waited < 50) begin
      tick();
      waited++;
    end
    check("send_ready", 64'(desc_ready), 64'd1);
    if (desc_ready) exp_q.push_back(a);
    tick();
    desc_valid = 1'b0;
  endtask

  task automatic wait_comp(input int target);
    int n;
    n = 0;
    while (comp_cnt < target && n < 300) begin
      tick();
      n++;
    end
    check("comp_count", 64'(comp_cnt), 64'(target));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    check("idle", 64'(busy), 64'd0);
  endtask

  initial begin
    int w, maxw, base;
    rst = 1'b1; desc_addr = '0; desc_valid = 1'b0; clear_err = 1'b0;
    pready_tb = 1'b1; err_en = 1'b0; err_addr = '0;
    tick(); tick();
    check("rst_psel", 64'(apb_req.psel), 64'd0);
    check("rst_req", 64'(apb_req), 64'd0);
    check("rst_ready", 64'(desc_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_errcnt", 64'(err_cnt), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    rst = 1'b0;
    tick();

    // 1: single write latency
    send(64'h0000_0001_0000_1000, w);                 // accepted at edge N
    check("t1_n_psel", 64'(apb_req.psel), 64'd0);
    check("t1_n_busy", 64'(busy), 64'd1);
    tick();                                            // N+1: SETUP
    check("t1_setup_psel", 64'(apb_req.psel), 64'd1);
    check("t1_setup_pen", 64'(apb_req.penable), 64'd0);
    check("t1_setup_pwdata", apb_req.pwdata, 64'h0000_0001_0000_1000);
    check("t1_setup_paddr", 64'(apb_req.paddr), 64'(Offs));
    check("t1_setup_pstrb", 64'(apb_req.pstrb), 64'hFF);
    check("t1_setup_pprot", 64'(apb_req.pprot), 64'd0);
    tick();                                            // N+2: ACCESS
    check("t1_access_pen", 64'(apb_req.penable), 64'd1);
    check("t1_access_psel", 64'(apb_req.psel), 64'd1);
    tick();                                            // N+3: completion
    check("t1_done_psel", 64'(apb_req.psel), 64'd0);
    tick();                                            // N+4
    check("t1_busy", 64'(busy), 64'd0);
    check("t1_sb_empty", 64'(exp_q.size()), 64'd0);

    // 2: four back-to-back writes, zero-wait responder
    base = comp_cnt; comp_cyc.delete(); maxw = 0;
    for (int i = 0; i < 4; i++) begin
      send(64'hA000_0000_0000_0100 + 64'(i), w);
      if (w > maxw) maxw = w;
    end
    check("t2_ready_drop", 64'(maxw <= 1), 64'd1);
    wait_comp(base + 4);
    for (int i = 0; i < 3; i++) check("t2_gap", 64'(comp_cyc[i+1] - comp_cyc[i]), 64'd2);
    wait_idle();
    check("t2_sb_empty", 64'(exp_q.size()), 64'd0);

    // 3: responder stalls while the FIFO fills
    pready_tb = 1'b0;
    base = comp_cnt;
    for (int i = 0; i < 4; i++) send(64'hB000_0000_0000_0200 + 64'(i), w);
    check("t3_full", 64'(desc_ready), 64'd0);
    desc_addr = 64'hB000_0000_0000_0204; desc_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t3_psel", 64'(apb_req.psel & apb_req.penable), 64'd1);
      check("t3_paddr", 64'(apb_req.paddr), 64'(Offs));
      check("t3_pwdata", apb_req.pwdata, 64'hB000_0000_0000_0200);
      check("t3_ready", 64'(desc_ready), 64'd0);
      tick();
    end
    pready_tb = 1'b1;
    send(64'hB000_0000_0000_0204, w);
    wait_comp(base + 5);
    wait_idle();
    check("t3_sb_empty", 64'(exp_q.size()), 64'd0);

    // 4: stall monitor with StallCycles=8
    pready_tb = 1'b0;
    base = comp_cnt;
    send(64'hC000_0000_0000_0300, w);                 // edge N
    repeat (9) tick();                                 // N+9: 7 ACCESS cycles done
    check("t4_stall_early", 64'(stall), 64'd0);
    tick();                                            // N+10: 8th ACCESS cycle done
    check("t4_stall_rise", 64'(stall), 64'd1);
    repeat (10) tick();
    check("t4_stall_hold", 64'(stall), 64'd1);
    pready_tb = 1'b1;
    tick();
    check("t4_stall_fall", 64'(stall), 64'd0);
    check("t4_psel", 64'(apb_req.psel), 64'd0);
    wait_comp(base + 1);
    wait_idle();

    // 5: PSLVERR on the second of three writes
    err_pulses = 0; err_en = 1'b1; err_addr = 64'hD000_0000_0000_0401;
    base = comp_cnt;
    for (int i = 0; i < 3; i++) send(64'hD000_0000_0000_0400 + 64'(i), w);
    wait_comp(base + 3);
    repeat (3) tick();
    check("t5_err_pulses", 64'(err_pulses), 64'd1);
    check("t5_err_cnt", 64'(err_cnt), 64'd1);
    check("t5_sb_empty", 64'(exp_q.size()), 64'd0);
    err_en = 1'b0;
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("t5_err_clr", 64'(err_cnt), 64'd0);

    // 6: reset during ACCESS
    pready_tb = 1'b0;
    send(64'hE000_0000_0000_0500, w);
    tick(); tick();
    check("t6_in_access", 64'(apb_req.penable), 64'd1);
    rst = 1'b1;
    #1;
    check("t6_psel", 64'(apb_req.psel), 64'd0);
    check("t6_pen", 64'(apb_req.penable), 64'd0);
    check("t6_ready", 64'(desc_ready), 64'd1);
    check("t6_busy", 64'(busy), 64'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    pready_tb = 1'b1;
    base = comp_cnt;
    send(64'hE000_0000_0000_0501, w);
    wait_comp(base + 1);
    wait_idle();
    check("t6_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
